// File: rtl/sram_scan_sequencer.sv
// sram_scan_sequencer: serialises one SRAM request into the 112-bit harness scan frame, strobes the access and returns read data (optional frame check via SCAN_FRAME_CHECK_EN)
module sram_scan_sequencer #(
  parameter int SEL_W    = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MASK_W   = 4,
  parameter int SCAN_LEN = 112
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [SEL_W-1:0]  req_sel_i,
  input  logic              req_csb0_i,
  input  logic              req_csb1_i,
  input  logic              req_web0_i,
  input  logic              req_web1_i,
  input  logic [MASK_W-1:0] req_wmask0_i,
  input  logic [MASK_W-1:0] req_wmask1_i,
  input  logic [ADDR_W-1:0] req_addr0_i,
  input  logic [ADDR_W-1:0] req_addr1_i,
  input  logic [DATA_W-1:0] req_din0_i,
  input  logic [DATA_W-1:0] req_din1_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_dout0_o,
  output logic [DATA_W-1:0] rsp_dout1_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic              scan_en_o,
  output logic              scan_in_o,
  output logic              sram_load_o,
  output logic              global_csb_o,
  input  logic              scan_out_i
);
  localparam int CW    = $clog2(SCAN_LEN);
  localparam int D0_HI = SCAN_LEN - 1 - SEL_W - ADDR_W;
  localparam int D0_LO = D0_HI - DATA_W + 1;
  localparam int D1_LO = 2 + MASK_W;
  localparam int D1_HI = D1_LO + DATA_W - 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_LEN - 1);
  typedef enum logic [2:0] {IDLE, SHIFT_IN, STROBE, CAPTURE, LOAD, SHIFT_OUT, DONE} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [SCAN_LEN-1:0] sh_q, cap_q, frame_d, cap_d;
  logic rd_q, err_q, mis;
  logic rsp_valid_q, rsp_err_q, scan_en_q, scan_in_q, sram_load_q, global_csb_q;
  logic [DATA_W-1:0] dout0_q, dout1_q;
  assign frame_d = {req_sel_i, req_addr0_i, req_din0_i, req_csb0_i, req_web0_i, req_wmask0_i,
                    req_addr1_i, req_din1_i, req_csb1_i, req_web1_i, req_wmask1_i};
  assign cap_d = {cap_q[SCAN_LEN-2:0], scan_out_i};
`ifdef SCAN_FRAME_CHECK_EN
  localparam logic [CW-1:0] D0_FIRST = CW'(SCAN_LEN - 1 - D0_HI);
  localparam logic [CW-1:0] D0_LAST  = CW'(SCAN_LEN - 1 - D0_LO);
  localparam logic [CW-1:0] D1_FIRST = CW'(SCAN_LEN - 1 - D1_HI);
  localparam logic [CW-1:0] D1_LAST  = CW'(SCAN_LEN - 1 - D1_LO);
  logic in_din;
  // The din fields carry read data back, so only the control/address bits are compared;
  // case inequality makes an unknown scan_out count as a mismatch.
  assign in_din = (cnt_q >= D0_FIRST && cnt_q <= D0_LAST) || (cnt_q >= D1_FIRST && cnt_q <= D1_LAST);
  assign mis = !in_din && (scan_out_i !== sh_q[SCAN_LEN-1]);
`else
  assign mis = 1'b0;
`endif
  assign req_ready_o  = state_q == IDLE;
  assign busy_o       = state_q != IDLE;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dout0_o  = dout0_q;
  assign rsp_dout1_o  = dout1_q;
  assign rsp_err_o    = rsp_err_q;
  assign scan_en_o    = scan_en_q;
  assign scan_in_o    = scan_in_q;
  assign sram_load_o  = sram_load_q;
  assign global_csb_o = global_csb_q;
  // Sequencer FSM; sh_q rotates once per shifted bit so it holds the sent frame again for the compare on the way out
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      cap_q        <= '0;
      rd_q         <= 1'b0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      dout0_q      <= '0;
      dout1_q      <= '0;
      scan_en_q    <= 1'b0;
      scan_in_q    <= 1'b0;
      sram_load_q  <= 1'b0;
      global_csb_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          state_q   <= SHIFT_IN;
          cnt_q     <= '0;
          sh_q      <= {frame_d[SCAN_LEN-2:0], frame_d[SCAN_LEN-1]};
          scan_in_q <= frame_d[SCAN_LEN-1];
          scan_en_q <= 1'b1;
          rd_q      <= (~req_csb0_i & req_web0_i) | (~req_csb1_i & req_web1_i);
          err_q     <= 1'b0;
        end
        SHIFT_IN: if (cnt_q == LAST) begin
          state_q      <= STROBE;
          cnt_q        <= '0;
          scan_en_q    <= 1'b0;
          scan_in_q    <= 1'b0;
          global_csb_q <= 1'b0;
        end else begin
          cnt_q     <= cnt_q + 1'b1;
          scan_in_q <= sh_q[SCAN_LEN-1];
          sh_q      <= {sh_q[SCAN_LEN-2:0], sh_q[SCAN_LEN-1]};
        end
        STROBE: begin
          global_csb_q <= 1'b1;
          state_q      <= rd_q ? CAPTURE : DONE;
          rsp_valid_q  <= !rd_q;
          rsp_err_q    <= 1'b0;
        end
        CAPTURE: begin
          state_q     <= LOAD;
          sram_load_q <= 1'b1;
        end
        LOAD: begin
          state_q     <= SHIFT_OUT;
          sram_load_q <= 1'b0;
          scan_en_q   <= 1'b1;
        end
        SHIFT_OUT: begin
          cap_q <= cap_d;
          sh_q  <= {sh_q[SCAN_LEN-2:0], sh_q[SCAN_LEN-1]};
          err_q <= err_q | mis;
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            cnt_q       <= '0;
            scan_en_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q | mis;
            dout0_q     <= cap_d[D0_HI:D0_LO];
            dout1_q     <= cap_d[D1_HI:D1_LO];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_scan_sequencer.sv
// tb_sram_scan_sequencer: directed requests against a behavioural scan harness, scoreboard-checked responses
module tb_sram_scan_sequencer;
`ifdef SCAN_FRAME_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b1;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_ready, req_csb0 = 1'b1, req_csb1 = 1'b1, req_web0 = 1'b1, req_web1 = 1'b1;
  logic [3:0] req_sel = '0, req_wmask0 = '0, req_wmask1 = '0;
  logic [15:0] req_addr0 = '0, req_addr1 = '0;
  logic [31:0] req_din0 = '0, req_din1 = '0, rsp_dout0, rsp_dout1;
  logic rsp_valid, rsp_err, busy, scan_en, scan_in, sram_load, global_csb, scan_out;

  sram_scan_sequencer dut (
    .clk_i(clk), .resetn_i(resetn), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_sel_i(req_sel), .req_csb0_i(req_csb0), .req_csb1_i(req_csb1),
    .req_web0_i(req_web0), .req_web1_i(req_web1), .req_wmask0_i(req_wmask0), .req_wmask1_i(req_wmask1),
    .req_addr0_i(req_addr0), .req_addr1_i(req_addr1), .req_din0_i(req_din0), .req_din1_i(req_din1),
    .rsp_valid_o(rsp_valid), .rsp_dout0_o(rsp_dout0), .rsp_dout1_o(rsp_dout1), .rsp_err_o(rsp_err),
    .busy_o(busy), .scan_en_o(scan_en), .scan_in_o(scan_in), .sram_load_o(sram_load),
    .global_csb_o(global_csb), .scan_out_i(scan_out)
  );

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [111:0] act, logic [111:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Harness model: scan register, SRAM macros keyed by {sel,addr}, dout latches
  logic [111:0] sr = '0, snap = '0;
  logic [31:0] hd0 = '0, hd1 = '0;
  logic [31:0] mem [int];
  logic flip = 1'b0;
  int strobes = 0, loads = 0;
  assign scan_out = sr[111];

  function automatic logic [31:0] rdm(int k);
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] m);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    int k0, k1;
    k0 = int'(sr[111:108]) * 65536 + int'(sr[107:92]);
    k1 = int'(sr[111:108]) * 65536 + int'(sr[53:38]);
    if (scan_en) sr <= {sr[110:0], scan_in};
    else if (sram_load) begin
      sr <= {sr[111] ^ flip, sr[110:92], hd0, sr[59:38], hd1, sr[5:0]};
      loads++;
    end
    if (!global_csb) begin
      snap = sr;
      strobes++;
      if (!sr[59]) begin
        if (!sr[58]) mem[k0] = merge(rdm(k0), sr[91:60], sr[57:54]);
        else hd0 = rdm(k0);
      end
      if (!sr[5]) begin
        if (!sr[4]) mem[k1] = merge(rdm(k1), sr[37:6], sr[3:0]);
        else hd1 = rdm(k1);
      end
    end
  end

  typedef struct {
    logic [111:0] frame;
    logic [31:0] d0, d1;
    logic err;
    int lat, nload, acc;
  } exp_t;
  exp_t q[$];

  // Monitor: every rsp_valid pops one expectation
  int last_strobes = 0, last_loads = 0;
  always @(negedge clk) begin
    exp_t e;
    if (resetn && rsp_valid) begin
      if (q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e = q.pop_front();
        chk("latency", cyc - e.acc + 1, e.lat);
        chk("dout0", rsp_dout0, e.d0);
        chk("dout1", rsp_dout1, e.d1);
        chk("err", rsp_err, e.err);
        chk("scanned_frame", snap, e.frame);
        chk("csb_strobes", strobes - last_strobes, 1);
        chk("load_strobes", loads - last_loads, e.nload);
      end
      last_strobes = strobes;
      last_loads = loads;
    end
  end

  task automatic send(logic [3:0] s, logic [15:0] a0, logic [31:0] d0, logic c0, logic w0, logic [3:0] m0,
                      logic [15:0] a1, logic [31:0] d1, logic c1, logic w1, logic [3:0] m1,
                      logic [31:0] e0, logic [31:0] e1, logic ee);
    exp_t e;
    logic rd;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 600) begin @(negedge clk); n++; end
    if (!req_ready) chk("ready_timeout", 0, 1);
    {req_sel, req_addr0, req_din0, req_csb0, req_web0, req_wmask0} = {s, a0, d0, c0, w0, m0};
    {req_addr1, req_din1, req_csb1, req_web1, req_wmask1} = {a1, d1, c1, w1, m1};
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rd = (~c0 & w0) | (~c1 & w1);
    e.frame = {s, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
    e.d0 = e0; e.d1 = e1; e.err = ee;
    e.lat = rd ? 228 : 114;
    e.nload = rd ? 1 : 0;
    e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && q.size() != 0; i++) @(negedge clk);
    chk("rsp_timeout_pending", q.size(), 0);
    q.delete();
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_global_csb"}, global_csb, 1);
    chk({tag, "_scan_en"}, scan_en, 0);
    chk({tag, "_scan_in"}, scan_in, 0);
    chk({tag, "_sram_load"}, sram_load, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
  endtask

  initial begin
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_err", rsp_err, 0);
    chk("reset_dout0", rsp_dout0, 0);
    chk("reset_dout1", rsp_dout1, 0);
    resetn = 1'b1;
    // writes: port0 addr1=5, port1 addr2=40, then dual read
    send(4'h0, 16'd1, 32'd5, 0, 0, 4'hF, 16'd0, 32'd0, 1, 1, 4'h0, 32'd0, 32'd0, 0); drain();
    send(4'h0, 16'd0, 32'd0, 1, 1, 4'h0, 16'd2, 32'd40, 0, 0, 4'hF, 32'd0, 32'd0, 0); drain();
    send(4'h0, 16'd1, 32'd0, 0, 1, 4'h0, 16'd2, 32'd0, 0, 1, 4'h0, 32'd5, 32'd40, 0); drain();
    // single port on macro 8
    send(4'h8, 16'd1, 32'hDEADBEEF, 0, 0, 4'hF, 16'd0, 32'd0, 1, 1, 4'h0, 32'd5, 32'd40, 0); drain();
    send(4'h8, 16'd1, 32'd0, 0, 1, 4'h0, 16'd0, 32'd0, 1, 1, 4'h0, 32'hDEADBEEF, 32'd40, 0); drain();
    // both ports deselected: full write sequence, no access
    send(4'h2, 16'd3, 32'hFFFF, 1, 0, 4'hF, 16'd3, 32'hFFFF, 1, 0, 4'hF, 32'hDEADBEEF, 32'd40, 0); drain();
    // reset in the middle of SHIFT_IN discards the partial frame
    send(4'h3, 16'd7, 32'hAAAAAAAA, 0, 0, 4'hF, 16'd0, 32'd0, 1, 1, 4'h0, 32'd0, 32'd0, 0);
    repeat (50) @(posedge clk);
    #1 resetn = 1'b0;
    #1 check_reset_outputs("midreset");
    q.delete();
    @(negedge clk) resetn = 1'b1;
    send(4'h3, 16'd7, 32'h12345678, 0, 0, 4'hF, 16'd0, 32'd0, 1, 1, 4'h0, 32'd0, 32'd0, 0); drain();
    send(4'h3, 16'd7, 32'd0, 0, 1, 4'h0, 16'd0, 32'd0, 1, 1, 4'h0, 32'h12345678, 32'd40, 0); drain();
    // corrupted sel bit on the return path; a write held on req_valid while busy must be ignored
    flip = 1'b1;
    send(4'h8, 16'd1, 32'd0, 0, 1, 4'h0, 16'd0, 32'd0, 1, 1, 4'h0, 32'hDEADBEEF, 32'd40, CHK_EN);
    repeat (20) @(negedge clk);
    {req_sel, req_addr0, req_din0, req_csb0, req_web0, req_wmask0} = {4'h8, 16'd1, 32'd0, 1'b0, 1'b0, 4'hF};
    req_valid = 1'b1;
    @(negedge clk);
    chk("busy_during_op", busy, 1);
    chk("ready_during_op", req_ready, 0);
    repeat (100) @(negedge clk);
    req_valid = 1'b0;
    drain();
    flip = 1'b0;
    send(4'h8, 16'd1, 32'd0, 0, 1, 4'h0, 16'd0, 32'd0, 1, 1, 4'h0, 32'hDEADBEEF, 32'd40, 0); drain();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
